y86_seq_controller: RTL

Multi-cycle sequencer for the Y86-64 SEQ datapath. Steps each instruction through fetch, decode, execute, memory, writeback and PC-update, one stage per state. Owns the architectural condition-code register and the branch/cmov condition, and drives the per-stage enables consumed by fetch, decode, execute, memory and writeback. Sits beside the execute stage: the execute stage supplies raw ALU flags, and this block latches them and returns a stable `cnd`.

---
 rtl/y86_pkg.sv | 54 +++++
 rtl/cond_eval.sv | 35 +++
 rtl/y86_seq_controller.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 SEQ controller: instruction codes,
// condition function codes, FSM states, status codes and CC bit positions.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE  = 4'h1;
  localparam logic [3:0] C_L   = 4'h2;
  localparam logic [3:0] C_E   = 4'h3;
  localparam logic [3:0] C_NE  = 4'h4;
  localparam logic [3:0] C_GE  = 4'h5;
  localparam logic [3:0] C_G   = 4'h6;

  localparam int CC_ZF = 2;
  localparam int CC_SF = 1;
  localparam int CC_OF = 0;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_PCUPD     = 3'd6,
    S_HALT      = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_t;

  // Instructions that touch data memory and therefore pass through MEMORY.
  function automatic logic isMemOp(input logic [3:0] icode);
    return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
           (icode == I_RET) || (icode == I_PUSHQ) || (icode == I_POPQ);
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluation from ifun and {zf,sf,of}.
module cond_eval
  import y86_pkg::*;
(
  input  logic [3:0] i_ifun,
  input  logic [2:0] i_cc,
  output logic       o_cnd
);

  logic w_zf;
  logic w_sf;
  logic w_of;
  logic w_lt;

  assign w_zf = i_cc[CC_ZF];
  assign w_sf = i_cc[CC_SF];
  assign w_of = i_cc[CC_OF];
  assign w_lt = w_sf ^ w_of;

  // Map each condition function onto the signed-compare flag expression.
  always_comb begin
    o_cnd = 1'b0;
    case (i_ifun)
      C_YES:   o_cnd = 1'b1;
      C_LE:    o_cnd = w_lt | w_zf;
      C_L:     o_cnd = w_lt;
      C_E:     o_cnd = w_zf;
      C_NE:    o_cnd = ~w_zf;
      C_GE:    o_cnd = ~w_lt;
      C_G:     o_cnd = ~w_lt & ~w_zf;
      default: o_cnd = 1'b0;
    endcase
  end

endmodule

// File: rtl/y86_seq_controller.sv
// Multi-cycle SEQ sequencer: walks each instruction through its stages,
// owns the condition codes and branch condition, and counts retirements.
module y86_seq_controller
  import y86_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [3:0]  i_icode,
  input  logic [3:0]  i_ifun,
  input  logic        i_instr_valid,
  input  logic        i_imem_error,
  input  logic        i_alu_zf,
  input  logic        i_alu_sf,
  input  logic        i_alu_of,
  input  logic        i_dmem_ack,
  input  logic        i_dmem_error,
  output logic [2:0]  o_state,
  output logic        o_fetch_en,
  output logic        o_decode_en,
  output logic        o_exec_en,
  output logic        o_mem_req,
  output logic        o_wb_en,
  output logic        o_pc_en,
  output logic [2:0]  o_cc,
  output logic        o_cnd,
  output logic [1:0]  o_stat,
  output logic [31:0] o_instr_cnt
);

  localparam int WCW = $clog2(MEM_TIMEOUT + 1);

  state_t      r_state;
  stat_t       r_stat;
  logic [2:0]  r_cc;
  logic        r_cnd;
  logic [31:0] r_instrCnt;
  logic [WCW-1:0] r_waitCnt;
  logic        r_fetchEn;
  logic        r_decodeEn;
  logic        r_execEn;
  logic        r_memReq;
  logic        r_wbEn;
  logic        r_pcEn;

  state_t      w_nextState;
  stat_t       w_nextStat;
  logic        w_cntInc;
  logic        w_condRaw;
  logic        w_timedOut;

  cond_eval u_condEval (
    .i_ifun (i_ifun),
    .i_cc   (r_cc),
    .o_cnd  (w_condRaw)
  );

  // The wait counter holds the MEMORY cycles already spent without an ack.
  assign w_timedOut = (int'(r_waitCnt) == (MEM_TIMEOUT - 1));

  // Next-state, next-status and retirement decision for the current state.
  always_comb begin
    w_nextState = r_state;
    w_nextStat  = r_stat;
    w_cntInc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_nextState = S_FETCH;
      end
      S_FETCH: begin
        if (i_imem_error) begin
          w_nextState = S_HALT;
          w_nextStat  = STAT_ADR;
        end else if (!i_instr_valid) begin
          w_nextState = S_HALT;
          w_nextStat  = STAT_INS;
        end else if (i_icode == I_HALT) begin
          w_nextState = S_HALT;
          w_nextStat  = STAT_HLT;
          w_cntInc    = 1'b1;
        end else begin
          w_nextState = S_DECODE;
        end
      end
      S_DECODE:  w_nextState = S_EXECUTE;
      S_EXECUTE: w_nextState = isMemOp(i_icode) ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (i_dmem_ack) begin
          if (i_dmem_error) begin
            w_nextState = S_HALT;
            w_nextStat  = STAT_ADR;
          end else begin
            w_nextState = S_WRITEBACK;
          end
        end else if (w_timedOut) begin
          w_nextState = S_HALT;
          w_nextStat  = STAT_ADR;
        end
      end
      S_WRITEBACK: w_nextState = S_PCUPD;
      S_PCUPD: begin
        w_nextState = S_FETCH;
        w_cntInc    = 1'b1;
      end
      S_HALT: begin
        if (i_start) begin
          w_nextState = S_FETCH;
          w_nextStat  = STAT_AOK;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Register state, status, flags, counters and the Moore stage strobes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_stat     <= STAT_AOK;
      r_cc       <= 3'b100;
      r_cnd      <= 1'b0;
      r_instrCnt <= '0;
      r_waitCnt  <= '0;
      r_fetchEn  <= 1'b0;
      r_decodeEn <= 1'b0;
      r_execEn   <= 1'b0;
      r_memReq   <= 1'b0;
      r_wbEn     <= 1'b0;
      r_pcEn     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_stat     <= w_nextStat;
      r_fetchEn  <= (w_nextState == S_FETCH);
      r_decodeEn <= (w_nextState == S_DECODE);
      r_execEn   <= (w_nextState == S_EXECUTE);
      r_memReq   <= (w_nextState == S_MEMORY);
      r_wbEn     <= (w_nextState == S_WRITEBACK);
      r_pcEn     <= (w_nextState == S_PCUPD);
      if (w_cntInc) r_instrCnt <= r_instrCnt + 32'd1;
      r_waitCnt <= ((r_state == S_MEMORY) && (w_nextState == S_MEMORY)) ?
                   r_waitCnt + 1'b1 : '0;
      if (r_state == S_EXECUTE) begin
        if (i_icode == I_OPQ) r_cc <= {i_alu_zf, i_alu_sf, i_alu_of};
        r_cnd <= ((i_icode == I_RRMOVQ) || (i_icode == I_JXX)) ? w_condRaw : 1'b0;
      end
    end
  end

  assign o_state     = r_state;
  assign o_stat      = r_stat;
  assign o_cc        = r_cc;
  assign o_cnd       = r_cnd;
  assign o_instr_cnt = r_instrCnt;
  assign o_fetch_en  = r_fetchEn;
  assign o_decode_en = r_decodeEn;
  assign o_exec_en   = r_execEn;
  assign o_mem_req   = r_memReq;
  assign o_wb_en     = r_wbEn;
  assign o_pc_en     = r_pcEn;

endmodule
